data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder for the memory-access stage: services its we/data_addr/din
//  requests and returns dout. Word-addressed RAM with a configurable registered read
//  latency. Holds the pipeline via stall while a read is in flight. Flags misaligned
//  accesses in a sticky error bit.
// PARAMETERS
//  ADDR_W    12  word-index width; RAM depth = 2**ADDR_W 32-bit words
//  READ_LAT  2   read latency in cycles, legal range 1..4 (checked at elaboration)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rstn          in   1   synchronous active-low reset
//  re            in   1   load request from memory-access stage
//  we            in   1   store request from memory-access stage
//  data_addr     in   32  byte address; word index = data_addr[ADDR_W+1:2]
//  din           in   32  store data
//  dout          out  32  load data; valid in the cycle stall deasserts for a load
//  stall         out  1   hold request and upstream stages while 1
//  misalign_err  out  1   sticky: some access had data_addr[1:0] != 0
// BEHAVIOUR
//  Reset (rstn=0 at edge): state=IDLE, cnt=0, dout=0, misalign_err=0.
//    stall=0 in the following cycle. RAM contents are NOT cleared.
//  Reset mid-read: pending read is abandoned; no dout update.
//  Upper address bits above ADDR_W+1 are ignored, so addresses wrap modulo RAM size.
//  misaligned = data_addr[1:0] != 0
//  FSM states: IDLE, BUSY. Down-counter cnt is 2 bits wide.
//  IDLE:
//   - we=1: if !misaligned, mem[idx] <= din at the edge. No stall. Stay IDLE.
//     re is ignored when we=1: the write wins and no read starts.
//   - re=1, we=0: latch idx and misaligned into areg/amis.
//     Go to BUSY with cnt = READ_LAT-1.
//     stall=1 combinationally in this request cycle.
//   - misaligned access with re or we set: misalign_err <= 1.
//  BUSY:
//   - stall = (cnt != 0). cnt decrements each cycle.
//   - In the cycle cnt==0: stall=0 and dout presents the read data.
//     Read data is mem[areg], or 0 if amis.
//     dout is a register, loaded at the edge entering the cnt==0 cycle.
//     Next state is IDLE.
//   - re and we are ignored in BUSY; upstream is stalled, and the completing
//     request is still on the inputs.
//  Read-back latency seen by the pipeline: load occupies READ_LAT cycles in MEM.
//    READ_LAT=1: stall=1 for the request cycle only; dout valid the next cycle.
//  stall is combinational from re, we, and state: stall = (IDLE & re & ~we) | (BUSY & cnt!=0).
//  dout holds its last value until the next read completes. Writes never change dout.
//  Write then read of the same address in consecutive cycles returns the new data.
//  RAM read is at the request edge plus any internal pipelining, after the prior write.
//  Single-port RAM: one access per cycle. No byte enables (word stores only).
// TESTING
//  1 Reset: hold rstn=0 for 2 cycles with re=1.
//    -> dout=0, stall=0, misalign_err=0 after release, then stall=1 on the next re.
//  2 Store/load: we, addr 0x10, din 0xDEADBEEF; next cycle re, addr 0x10.
//    -> READ_LAT=2: stall=1 for 2 cycles, then dout=0xDEADBEEF with stall=0.
//  3 Wrap: ADDR_W=12, store 0x1234 at 0x0000_4008, then load 0x8.
//    -> dout=0x1234.
//  4 Misaligned: store to 0x11 with din 0xFF, then load 0x10.
//    -> old value unchanged, misalign_err=1 and stays 1.
//    Load 0x13 -> dout=0 after normal latency.
//  5 Simultaneous re and we at addr 0x20.
//    -> write performed, stall=0, dout unchanged.
//  6 Reset asserted in the first BUSY cycle of a load.
//    -> next cycle IDLE, stall=0, dout=0; RAM contents intact on a subsequent read.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory-access stage.
// Word-addressed RAM with a registered read path of READ_LAT cycles. The upstream
// pipeline is held by stall while a load is in flight. Any misaligned access sets a
// sticky error flag.
module data_mem_responder #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] data_addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        misalign_err
);

  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("READ_LAT must be in 1..4");
    end
  endgenerate

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [1:0]  CntInit = 2'(READ_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   areg_q;
  logic                amis_q;
  logic [31:0]         mem [Depth];

  logic [ADDR_W-1:0]   idx;
  logic                mis;
  logic                req_rd;
  logic                wr_en;
  logic                ld_dout;
  logic [ADDR_W-1:0]   ld_addr;
  logic                ld_mis;
  logic                unused_addr;

  // Upper address bits are dropped, so addresses wrap modulo the RAM size.
  assign idx         = data_addr[ADDR_W+1:2];
  assign mis         = |data_addr[1:0];
  assign unused_addr = ^data_addr[31:ADDR_W+2];

  assign req_rd = (state_q == StIdle) && re && !we;
  assign wr_en  = (state_q == StIdle) && we && !mis;

  // dout is loaded on the edge entering the cnt==0 cycle. With READ_LAT=1 that is the
  // request edge itself, before areg is latched, so the live index is used instead.
  always_comb begin
    ld_dout = 1'b0;
    ld_addr = areg_q;
    ld_mis  = amis_q;
    if (READ_LAT == 1) begin
      ld_dout = req_rd;
      ld_addr = idx;
      ld_mis  = mis;
    end else begin
      ld_dout = (state_q == StBusy) && (cnt_q == 2'd1);
    end
  end

  // State and countdown register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a load enters BUSY and counts down to the data cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_rd) begin
          state_d = StBusy;
          cnt_d   = CntInit;
        end
      end
      StBusy: begin
        if (cnt_q == 2'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: stall during the request cycle and every BUSY cycle before data
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      StIdle:  stall = re && !we;
      StBusy:  stall = (cnt_q != 2'd0);
      default: stall = 1'b0;
    endcase
  end

  // Latch the load address and its alignment at the request edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      areg_q <= '0;
      amis_q <= 1'b0;
    end else if (req_rd) begin
      areg_q <= idx;
      amis_q <= mis;
    end
  end

  // Read data register; holds until the next load completes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout <= 32'd0;
    end else if (ld_dout) begin
      dout <= ld_mis ? 32'd0 : mem[ld_addr];
    end
  end

  // Sticky misalignment flag, raised by any accepted misaligned request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      misalign_err <= 1'b0;
    end else if ((state_q == StIdle) && (re || we) && mis) begin
      misalign_err <= 1'b1;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      mem[idx] <= din;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by random
// traffic, compared against a transaction-level model of the memory.
module tb_data_mem_responder;

  localparam int unsigned AddrW   = 12;
  localparam int unsigned ReadLat = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        stall;
  logic        misalign_err;

  int n_vec = 0;
  int n_err = 0;

  // Model state: word contents by index, last loaded value, sticky error
  logic [31:0] mdl [int];
  logic [31:0] exp_dout;
  logic        exp_mis;

  data_mem_responder #(
    .ADDR_W  (AddrW),
    .READ_LAT(ReadLat)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .re          (re),
    .we          (we),
    .data_addr   (data_addr),
    .din         (din),
    .dout        (dout),
    .stall       (stall),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] a);
    return int'(a[AddrW+1:2]);
  endfunction

  // Store (optionally with re also high, which must not start a load)
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic with_re);
    @(negedge clk);
    we = 1'b1; re = with_re; data_addr = a; din = d;
    #1;
    check_eq("wr_stall", 32'(stall), 32'd0);
    @(posedge clk);
    if (a[1:0] == 2'b00) mdl[word_idx(a)] = d;
    else                 exp_mis = 1'b1;
    #1;
    we = 1'b0; re = 1'b0;
    check_eq("wr_dout_hold", dout, exp_dout);
    check_eq("wr_mis", 32'(misalign_err), 32'(exp_mis));
  endtask

  // Load: stall must last ReadLat sampled cycles, then data appears with stall low
  task automatic do_read(input logic [31:0] a, input bit check_data);
    int n;
    @(negedge clk);
    re = 1'b1; we = 1'b0; data_addr = a;
    #1;
    n = 0;
    while (stall && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    re = 1'b0;
    check_eq("rd_stall_cycles", 32'(n), 32'(ReadLat));
    if (a[1:0] != 2'b00) begin
      exp_mis  = 1'b1;
      exp_dout = 32'd0;
    end else if (mdl.exists(word_idx(a))) begin
      exp_dout = mdl[word_idx(a)];
    end else begin
      exp_dout = dout;
    end
    if (check_data) check_eq("rd_dout", dout, exp_dout);
    check_eq("rd_mis", 32'(misalign_err), 32'(exp_mis));
  endtask

  initial begin
    exp_dout = 32'd0;
    exp_mis  = 1'b0;

    // 1: reset held two cycles with re high
    rstn = 1'b0; re = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1; re = 1'b0;
    #1;
    check_eq("rst_dout", dout, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_mis", 32'(misalign_err), 32'd0);
    re = 1'b1;
    #1;
    check_eq("rst_stall_on_re", 32'(stall), 32'd1);
    re = 1'b0;
    #1;

    // 2: store then load in the next cycle
    do_write(32'h10, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h10, 1'b1);
    check_eq("st_ld", dout, 32'hDEAD_BEEF);

    // 3: upper address bits wrap
    do_write(32'h0000_4008, 32'h1234, 1'b0);
    do_read(32'h8, 1'b1);
    check_eq("wrap", dout, 32'h1234);

    // 4: misaligned store is dropped, flag sticks, misaligned load returns 0
    do_write(32'h11, 32'hFF, 1'b0);
    do_read(32'h10, 1'b1);
    check_eq("mis_old", dout, 32'hDEAD_BEEF);
    check_eq("mis_sticky", 32'(misalign_err), 32'd1);
    do_read(32'h13, 1'b1);
    check_eq("mis_ld_zero", dout, 32'd0);

    // 5: re and we together: write wins, no stall, dout unchanged
    do_write(32'h20, 32'hCAFE_F00D, 1'b1);
    check_eq("rw_dout", dout, 32'd0);
    do_read(32'h20, 1'b1);
    check_eq("rw_data", dout, 32'hCAFE_F00D);

    // 6: reset in the first BUSY cycle of a load
    @(negedge clk);
    re = 1'b1; data_addr = 32'h10;
    @(negedge clk);
    rstn = 1'b0; re = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_dout = 32'd0;
    exp_mis  = 1'b0;
    check_eq("midrd_stall", 32'(stall), 32'd0);
    check_eq("midrd_dout", dout, 32'd0);
    check_eq("midrd_mis", 32'(misalign_err), 32'd0);
    @(posedge clk);
    #1;
    check_eq("midrd_idle", 32'(stall), 32'd0);
    do_read(32'h10, 1'b1);
    check_eq("midrd_ram", dout, 32'hDEAD_BEEF);

    // Random traffic over a small initialised window with random upper bits
    for (int i = 0; i < 32; i++) do_write(32'(i) << 2, $urandom, 1'b0);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      logic [31:0] hi;
      int          op;
      op = int'($urandom_range(0, 3));
      hi = $urandom;
      a  = {hi[31:AddrW+2], 12'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (op)
        0, 1:    do_write(a, $urandom, 1'b0);
        2:       do_read(a, 1'b1);
        default: do_write(a, $urandom, 1'b1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
